hub75_panel_rx: RTL

Receive-side model of the HUB75 LED-matrix port: samples the row address, dual-half RGB serial data, OE and LAT driven by the matrix scan driver, rebuilds each latched line pair into an on-chip frame store, and exposes a registered pixel readback port plus protocol error flags. Sits on the far side of the matrix driver, as a self-checking panel model in simulation and as an on-FPGA loopback monitor for bring-up.

---
 rtl/hub75_panel_rx_if.sv | 27 ++
 rtl/hub75_panel_rx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hub75_panel_rx_if.sv
// rtl/hub75_panel_rx_if.sv - HUB75 matrix port signal bundle (scan driver to panel)
interface hub75_panel_rx_if;
    logic A;
    logic B;
    logic C;
    logic D;
    logic R0;
    logic G0;
    logic B0;
    logic R1;
    logic G1;
    logic B1;
    logic OE;
    logic LAT;

    modport master (
        output A, B, C, D,
        output R0, G0, B0, R1, G1, B1,
        output OE, LAT
    );

    modport slave (
        input A, B, C, D,
        input R0, G0, B0, R1, G1, B1,
        input OE, LAT
    );
endinterface

// File: rtl/hub75_panel_rx.sv
// rtl/hub75_panel_rx.sv - HUB75 receive model: line capture, frame store, readback, error flags
// Optional row-sequence check enabled by defining HUB75_RX_ROWCHK_EN.
module hub75_panel_rx #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    hub75_panel_rx_if.slave           hub,
    input  logic [$clog2(COLS)-1:0]   rd_x,
    input  logic [ROW_BITS:0]         rd_y,
    output logic [2:0]                rd_rgb,
    output logic [ROW_BITS-1:0]       cur_row,
    output logic                      line_done,
    output logic                      frame_done,
    output logic                      err_len,
    output logic                      err_ovr,
    output logic                      err_row,
    input  logic                      err_clr
);

    localparam int XW    = $clog2(COLS);
    localparam int W     = 3 * COLS;
    localparam int CW    = $clog2(2 * COLS + 1);
    localparam int DEPTH = 2 * (2 ** ROW_BITS);
    localparam logic [CW-1:0] CNT_LINE = CW'(COLS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(2 * COLS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_UP,
        S_WR_LO
    } state_t;

    state_t                state_q;
    logic [W-1:0]          up_sr_q;
    logic [W-1:0]          lo_sr_q;
    logic [CW-1:0]         cnt_q;
    logic                  lat_prev_q;
    logic [W-1:0]          hold_up_q;
    logic [W-1:0]          hold_lo_q;
    logic [ROW_BITS-1:0]   hold_row_q;
    logic [ROW_BITS-1:0]   cur_row_q;
    logic                  line_done_q;
    logic                  frame_done_q;
    logic                  err_len_q;
    logic                  err_ovr_q;
    logic [2:0]            rd_rgb_q;
    logic [W-1:0]          mem [DEPTH];

    logic                  shift_en;
    logic                  lat_evt;
    logic                  idle;
    logic                  len_new;
    logic                  ovr_new;
    logic [ROW_BITS-1:0]   addr;
    logic [W-1:0]          rd_word;
    logic [XW+1:0]         rd_bit;
    logic [2:0]            rd_pix;

    assign shift_en = hub.OE & ~hub.LAT;
    assign lat_evt  = hub.LAT & ~lat_prev_q;
    assign idle     = (state_q == S_IDLE);
    assign len_new  = lat_evt & idle & (cnt_q != CNT_LINE);
    assign ovr_new  = lat_evt & ~idle;
    assign addr     = ROW_BITS'({hub.D, hub.C, hub.B, hub.A});

    // Newest sample enters at the top so the oldest of the last COLS ends at x=0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            up_sr_q    <= '0;
            lo_sr_q    <= '0;
            cnt_q      <= '0;
            lat_prev_q <= 1'b0;
        end else begin
            lat_prev_q <= hub.LAT;
            if (shift_en) begin
                up_sr_q <= {hub.R0, hub.G0, hub.B0, up_sr_q[W-1:3]};
                lo_sr_q <= {hub.R1, hub.G1, hub.B1, lo_sr_q[W-1:3]};
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else if (lat_evt && idle) begin
                cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            hold_up_q    <= '0;
            hold_lo_q    <= '0;
            hold_row_q   <= '0;
            cur_row_q    <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_len_q    <= 1'b0;
            err_ovr_q    <= 1'b0;
        end else begin
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_len_q    <= (err_len_q & ~err_clr) | len_new;
            err_ovr_q    <= (err_ovr_q & ~err_clr) | ovr_new;
            case (state_q)
                S_IDLE: begin
                    if (lat_evt) begin
                        hold_up_q  <= up_sr_q;
                        hold_lo_q  <= lo_sr_q;
                        hold_row_q <= addr;
                        state_q    <= S_WR_UP;
                    end
                end
                S_WR_UP: begin
                    state_q <= S_WR_LO;
                end
                S_WR_LO: begin
                    state_q      <= S_IDLE;
                    cur_row_q    <= hold_row_q;
                    line_done_q  <= 1'b1;
                    frame_done_q <= &hold_row_q;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Frame store is never cleared; a reset during a write simply drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == S_WR_UP) begin
                mem[{1'b0, hold_row_q}] <= hold_up_q;
            end else if (state_q == S_WR_LO) begin
                mem[{1'b1, hold_row_q}] <= hold_lo_q;
            end
        end
    end

    assign rd_word = mem[rd_y];
    assign rd_bit  = {1'b0, rd_x, 1'b0} + {2'b00, rd_x};
    assign rd_pix  = rd_word[rd_bit +: 3];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_rgb_q <= '0;
        end else begin
            rd_rgb_q <= rd_pix;
        end
    end

`ifdef HUB75_RX_ROWCHK_EN
    logic have_prev_q;
    logic err_row_q;
    logic row_new;

    assign row_new = (state_q == S_WR_LO) && have_prev_q &&
                     (hold_row_q != cur_row_q + ROW_BITS'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            have_prev_q <= 1'b0;
            err_row_q   <= 1'b0;
        end else begin
            err_row_q <= (err_row_q & ~err_clr) | row_new;
            if (state_q == S_WR_LO) begin
                have_prev_q <= 1'b1;
            end
        end
    end

    assign err_row = err_row_q;
`else
    assign err_row = 1'b0;
`endif

    assign rd_rgb     = rd_rgb_q;
    assign cur_row    = cur_row_q;
    assign line_done  = line_done_q;
    assign frame_done = frame_done_q;
    assign err_len    = err_len_q;
    assign err_ovr    = err_ovr_q;

endmodule
